// File: rtl/random_choose.sv
// rtl/random_choose.sv - weighted pseudo-random segment selector
// Each enabled edge picks segment 0-3 with probability proportional to its weight.

module random_choose #(
  parameter int             WIDTH = 10,
  parameter logic [WIDTH:0] POLY  = 11'h500
) (
  input  logic           in_clock,
  input  logic           in_reset,
  input  logic           in_enable,
  input  logic [WIDTH:0] in_weight0,
  input  logic [WIDTH:0] in_weight1,
  input  logic [WIDTH:0] in_weight2,
  input  logic [WIDTH:0] in_weight3,
  input  logic [WIDTH:0] in_seed,
  output logic [1:0]     out_segment_number
);

  logic [WIDTH:0]     r_lfsr;
  logic               r_need_seed;
  logic [1:0]         r_segment;

  logic               w_fb;
  logic [WIDTH:0]     w_lfsr_next;
  logic [WIDTH:0]     w_seed_load;
  logic [WIDTH+2:0]   w_c0;
  logic [WIDTH+2:0]   w_c1;
  logic [WIDTH+2:0]   w_c2;
  logic [WIDTH+2:0]   w_total;
  logic [2*WIDTH+3:0] w_product;
  logic [WIDTH+2:0]   w_rand;
  logic [WIDTH:0]     w_unused_frac;
  logic [1:0]         w_choice;

  assign w_fb        = ^(r_lfsr & POLY);
  assign w_lfsr_next = {r_lfsr[WIDTH-1:0], w_fb};
  // An all-zero LFSR would lock up, so a zero seed is replaced by 1.
  assign w_seed_load = (in_seed == '0) ? {{WIDTH{1'b0}}, 1'b1} : in_seed;

  assign w_c0    = {2'b00, in_weight0};
  assign w_c1    = w_c0 + {2'b00, in_weight1};
  assign w_c2    = w_c1 + {2'b00, in_weight2};
  assign w_total = w_c2 + {2'b00, in_weight3};

  // Scale the LFSR fraction onto [0, total); the low bits are the discarded fraction.
  assign w_product = {{(WIDTH+3){1'b0}}, r_lfsr} * {{(WIDTH+1){1'b0}}, w_total};
  assign {w_rand, w_unused_frac} = w_product;

  always_comb begin
    w_choice = 2'd3;
    if (w_total == '0) begin
      w_choice = 2'd0;
    end else if (w_rand < w_c0) begin
      w_choice = 2'd0;
    end else if (w_rand < w_c1) begin
      w_choice = 2'd1;
    end else if (w_rand < w_c2) begin
      w_choice = 2'd2;
    end
  end

  always_ff @(posedge in_clock or negedge in_reset) begin
    if (!in_reset) begin
      r_lfsr      <= '0;
      r_need_seed <= 1'b1;
      r_segment   <= 2'd0;
    end else if (r_need_seed) begin
      r_lfsr      <= w_seed_load;
      r_need_seed <= 1'b0;
    end else if (in_enable) begin
      r_segment   <= w_choice;
      r_lfsr      <= w_lfsr_next;
    end
  end

  assign out_segment_number = r_segment;

endmodule

// File: tb/tb_random_choose.sv
// tb/tb_random_choose.sv - scoreboard bench for random_choose
// Stimulus pushes expected segment/LFSR per edge; a negedge monitor pops and compares.

module tb_random_choose;

  localparam int W = 10;

  typedef struct packed {
    logic [1:0]  seg;
    logic [W:0]  lfsr;
    logic [7:0]  tag;
    logic        cnt;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       en;
  logic [W:0] w0, w1, w2, w3, seed;
  logic [1:0] seg;

  exp_t       q[$];
  int         n_cmp = 0;
  int         n_err = 0;
  int         cnt[4];
  int         tag = 0;

  logic [W:0] m_lfsr;
  logic [1:0] m_seg;
  bit         m_need;

  int hv[12] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0};

  always #5 clk = ~clk;

  random_choose #(.WIDTH(W), .POLY(11'h500)) dut (
    .in_clock           (clk),
    .in_reset           (rst_n),
    .in_enable          (en),
    .in_weight0         (w0),
    .in_weight1         (w1),
    .in_weight2         (w2),
    .in_weight3         (w3),
    .in_seed            (seed),
    .out_segment_number (seg)
  );

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic logic [1:0] choose(input logic [W:0] l, input int a, input int b,
                                        input int c, input int d);
    int t, r;
    t = a + b + c + d;
    if (t == 0) return 2'd0;
    r = (int'(l) * t) >>> (W + 1);
    if (r < a) return 2'd0;
    if (r < a + b) return 2'd1;
    if (r < a + b + c) return 2'd2;
    return 2'd3;
  endfunction

  function automatic logic [W:0] step(input logic [W:0] l);
    return {l[W-1:0], l[10] ^ l[8]};
  endfunction

  // hand >= 0 overrides the model's segment with a hand-derived value
  task automatic tick(input int hand, input bit count);
    exp_t e;
    @(posedge clk);
    if (m_need) begin
      m_lfsr = (seed == '0) ? 11'd1 : seed;
      m_need = 0;
    end else if (en) begin
      m_seg  = choose(m_lfsr, int'(w0), int'(w1), int'(w2), int'(w3));
      m_lfsr = step(m_lfsr);
    end
    e.seg  = (hand >= 0) ? hand[1:0] : m_seg;
    e.lfsr = m_lfsr;
    e.tag  = tag[7:0];
    e.cnt  = count;
    q.push_back(e);
    #1;
  endtask

  task automatic drain();
    for (int i = 0; i < 10; i++) begin
      if (q.size() == 0) break;
      @(negedge clk);
      #1;
    end
    check("drain_empty", q.size(), 0);
  endtask

  task automatic set_w(input int a, input int b, input int c, input int d);
    w0 = a[W:0]; w1 = b[W:0]; w2 = c[W:0]; w3 = d[W:0];
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (q.size() > 0) begin
      e = q.pop_front();
      check($sformatf("seg_t%0d", e.tag), int'(seg), int'(e.seg));
      check($sformatf("lfsr_t%0d", e.tag), int'(dut.r_lfsr), int'(e.lfsr));
      if (e.cnt) cnt[seg]++;
    end
  end

  initial begin
    rst_n = 1'b0; en = 1'b1; seed = 11'd1;
    set_w(2, 4, 2, 0);
    m_need = 1; m_seg = 2'd0; m_lfsr = '0;

    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      check("reset_seg", int'(seg), 0);
      check("reset_lfsr", int'(dut.r_lfsr), 0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    tag = 1; tick(0, 0);
    seed = 11'h3ff;

    cnt = '{0, 0, 0, 0};
    tag = 2;
    for (int i = 0; i < 12; i++) tick(hv[i], 1);
    for (int i = 12; i < 2047; i++) tick(-1, 1);
    drain();
    check("dist_cnt0", cnt[0], 511);
    check("dist_cnt1", cnt[1], 1024);
    check("dist_cnt2", cnt[2], 512);
    check("dist_cnt3", cnt[3], 0);

    tag = 3;
    for (int i = 0; i < 20; i++) tick(-1, 0);
    en = 1'b0;
    for (int i = 0; i < 3; i++) tick(-1, 0);
    en = 1'b1;
    for (int i = 0; i < 20; i++) tick(-1, 0);

    tag = 4; set_w(0, 0, 0, 5);
    for (int i = 0; i < 30; i++) tick(3, 0);
    tag = 5; set_w(7, 0, 0, 0);
    for (int i = 0; i < 30; i++) tick(0, 0);
    tag = 6; set_w(0, 0, 0, 0);
    for (int i = 0; i < 30; i++) tick(0, 0);

    tag = 7; set_w(2, 4, 2, 0);
    for (int i = 0; i < 50; i++) begin
      tick(-1, 0);
      if (m_seg != 2'd0) break;
    end
    drain();
    check("pre_pulse_seg_nonzero", int'(seg != 2'd0), 1);
    seed = 11'd1;
    rst_n = 1'b0;
    #1;
    check("pulse_seg", int'(seg), 0);
    check("pulse_lfsr", int'(dut.r_lfsr), 0);
    rst_n = 1'b1;
    m_need = 1; m_seg = 2'd0; m_lfsr = '0;
    tag = 8; tick(0, 0);
    tag = 9;
    for (int i = 0; i < 12; i++) tick(hv[i], 0);

    drain();
    rst_n = 1'b0;
    seed  = 11'd0;
    @(negedge clk);
    check("reset2_seg", int'(seg), 0);
    rst_n = 1'b1;
    m_need = 1; m_seg = 2'd0; m_lfsr = '0;
    tag = 10; tick(0, 0);
    tag = 11;
    for (int i = 0; i < 12; i++) tick(hv[i], 0);

    tag = 12; set_w(2047, 2047, 2047, 2047);
    drain();
    cnt = '{0, 0, 0, 0};
    for (int i = 0; i < 2047; i++) tick(-1, 1);
    drain();
    check("max_cnt0", cnt[0], 511);
    check("max_cnt1", cnt[1], 512);
    check("max_cnt2", cnt[2], 512);
    check("max_cnt3", cnt[3], 512);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
